// File: rtl/ospi_flash_mem_pkg.sv
// Shared definitions for the OSPI flash memory model: command opcodes,
// status register bit positions, controller state encoding and a small
// counter-width helper.
package ospi_flash_pkg;

    typedef enum logic [2:0] {
        OP_READ   = 3'd0,
        OP_PROG   = 3'd1,
        OP_SERASE = 3'd2,
        OP_WREN   = 3'd3,
        OP_WRDI   = 3'd4,
        OP_RDSR   = 3'd5
    } op_e;

    localparam int SR_WIP = 0;
    localparam int SR_WEL = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROG  = 2'd1,
        ST_ERASE = 2'd2
    } state_e;

    // Width of a down-counter that must hold values 0..n-1 (at least 1 bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ospi_flash_mem_if.sv
// Command/response bundle between the OSPI front end (master) and the
// flash storage back end (slave).
//   cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_wdata : command handshake
//   rsp_valid/rsp_data                             : read/status response
//   busy/wel/err                                   : status and reject pulse
interface ospi_flash_mem_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              busy;
    logic              wel;
    logic              err;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_data, busy, wel, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_data, busy, wel, err
    );
endinterface

// File: rtl/ospi_flash_mem_array.sv
// Flash storage array: DATA_W x 2^ADDR_W words, one shared address port,
// synchronous write, asynchronous read. Powers up all-ones (erased) and is
// deliberately not touched by reset.
//   clk     : clock
//   we_i    : write enable
//   addr_i  : word address for both read and write
//   wdata_i : write data
//   rdata_o : read data at addr_i
module ospi_flash_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: {DATA_W{1'b1}}};

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ospi_flash_mem.sv
// Cycle-timed OSPI flash back end: READ, PROG (AND-only), sector erase,
// write-enable latch and status readout, with busy timing.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : command/response interface (slave side)
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | accepts any command
// ST_PROG  | program in flight, counting down to the commit edge
// ST_ERASE | sector erase, one word set to all-ones per cycle
module ospi_flash_mem
    import ospi_flash_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int SECTOR_W    = 4,
    parameter int PROG_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    ospi_flash_mem_if.slave  bus
);
    localparam int              PCW        = cnt_width(PROG_CYCLES);
    localparam logic [SECTOR_W:0] ERASE_LEN  = {1'b1, {SECTOR_W{1'b0}}};
    localparam logic [SECTOR_W:0] ERASE_LAST = {{SECTOR_W{1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic              wel_q, wel_d;
    logic [PCW-1:0]    prog_cnt_q, prog_cnt_d;
    logic [SECTOR_W:0] erase_cnt_q, erase_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              err_q, err_d;

    logic              busy, accept;
    logic [SECTOR_W:0] erase_off;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_wdata, arr_rdata;

    assign busy          = (state_q != ST_IDLE);
    assign bus.cmd_ready = !busy || (bus.cmd_op == OP_RDSR);
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    // Erase counter counts remaining words; offset into the sector rises 0..N-1.
    assign erase_off     = ERASE_LEN - erase_cnt_q;

    ospi_flash_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_array (
        .clk     (clk),
        .we_i    (arr_we),
        .addr_i  (arr_addr),
        .wdata_i (arr_wdata),
        .rdata_o (arr_rdata)
    );

    // Array port steering is kept apart from the FSM block so read data feeding
    // the response register does not form a loop through one process.
    always_comb begin
        arr_we    = 1'b0;
        arr_addr  = bus.cmd_addr;
        arr_wdata = data_q;
        case (state_q)
            ST_PROG: begin
                arr_addr  = addr_q;
                arr_we    = (prog_cnt_q == '0);
                arr_wdata = arr_rdata & data_q;
            end
            ST_ERASE: begin
                arr_addr  = {addr_q[ADDR_W-1:SECTOR_W], erase_off[SECTOR_W-1:0]};
                arr_we    = 1'b1;
                arr_wdata = {DATA_W{1'b1}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        wel_d       = wel_q;
        prog_cnt_d  = prog_cnt_q;
        erase_cnt_d = erase_cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        err_d       = 1'b0;

        // Only RDSR can be accepted while busy, so the command decode never
        // competes with the busy-state updates below.
        if (accept) begin
            case (bus.cmd_op)
                OP_READ: begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = arr_rdata;
                end
                OP_RDSR: begin
                    rsp_valid_d        = 1'b1;
                    rsp_data_d         = '0;
                    rsp_data_d[SR_WIP] = busy;
                    rsp_data_d[SR_WEL] = wel_q;
                end
                OP_WREN: wel_d = 1'b1;
                OP_WRDI: wel_d = 1'b0;
                OP_PROG: begin
                    if (wel_q) begin
                        state_d    = ST_PROG;
                        addr_d     = bus.cmd_addr;
                        data_d     = bus.cmd_wdata;
                        prog_cnt_d = PCW'(PROG_CYCLES - 1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_SERASE: begin
                    if (wel_q) begin
                        state_d     = ST_ERASE;
                        addr_d      = {bus.cmd_addr[ADDR_W-1:SECTOR_W], {SECTOR_W{1'b0}}};
                        erase_cnt_d = ERASE_LEN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: err_d = 1'b1;
            endcase
        end

        case (state_q)
            ST_PROG: begin
                if (prog_cnt_q == '0) begin
                    wel_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    prog_cnt_d = prog_cnt_q - PCW'(1);
                end
            end
            ST_ERASE: begin
                if (erase_cnt_q == ERASE_LAST) begin
                    wel_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    erase_cnt_d = erase_cnt_q - ERASE_LAST;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            wel_q       <= 1'b0;
            prog_cnt_q  <= '0;
            erase_cnt_q <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= {DATA_W{1'b1}};
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wel_q       <= wel_d;
            prog_cnt_q  <= prog_cnt_d;
            erase_cnt_q <= erase_cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.busy      = busy;
    assign bus.wel       = wel_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_ospi_flash_mem.sv
// Self-checking bench for ospi_flash_mem: directed scenarios with literal
// expectations, then randomized commands, all checked every cycle against a
// timestamp-based behavioural model of the flash.
module tb_ospi_flash_mem;
    import ospi_flash_pkg::*;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int SW = 4;
    localparam int PC = 4;
    localparam int SECT = 1 << SW;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    ospi_flash_mem_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    ospi_flash_mem #(.DATA_W(DW), .ADDR_W(AW), .SECTOR_W(SW), .PROG_CYCLES(PC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int npass = 0;
    int ntot  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Busy is tracked as "last busy edge index"; writes are applied at the edge
    // they are scheduled for.
    logic [DW-1:0] mem_m [1 << AW] = '{default: 8'hFF};
    int        cyc       = 0;
    int        busy_last = -1;
    int        kind      = 0;   // 1 = program pending, 2 = erase in progress
    int        e_start   = 0;
    int        e_base    = 0;
    int        p_addr    = 0;
    logic [DW-1:0] p_data = '0;
    bit        m_wel     = 1'b0;
    bit        exp_rv    = 1'b0;
    bit        exp_err   = 1'b0;
    logic [DW-1:0] exp_rd = 8'hFF;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_last = -1;
            kind      = 0;
            m_wel     = 1'b0;
            exp_rv    = 1'b0;
            exp_err   = 1'b0;
            exp_rd    = 8'hFF;
        end else begin
            int  e;
            bit  busy_pre, wel_pre, acc, nv, ne;
            logic [DW-1:0] rd;
            cyc++;
            e        = cyc;
            busy_pre = (e <= busy_last);
            wel_pre  = m_wel;
            acc      = bus.cmd_valid && (!busy_pre || bus.cmd_op == OP_RDSR);
            nv = 1'b0; ne = 1'b0; rd = exp_rd;
            if (busy_pre && kind == 1 && e == busy_last) begin
                mem_m[p_addr] = mem_m[p_addr] & p_data;
                m_wel = 1'b0;
            end
            if (busy_pre && kind == 2) begin
                mem_m[e_base + (e - e_start - 1)] = 8'hFF;
                if (e == busy_last) m_wel = 1'b0;
            end
            if (acc) begin
                case (bus.cmd_op)
                    OP_READ: begin nv = 1'b1; rd = mem_m[int'(bus.cmd_addr)]; end
                    OP_RDSR: begin nv = 1'b1; rd = '0; rd[0] = busy_pre; rd[1] = wel_pre; end
                    OP_WREN: m_wel = 1'b1;
                    OP_WRDI: m_wel = 1'b0;
                    OP_PROG: begin
                        if (wel_pre) begin
                            kind = 1; busy_last = e + PC;
                            p_addr = int'(bus.cmd_addr); p_data = bus.cmd_wdata;
                        end else ne = 1'b1;
                    end
                    OP_SERASE: begin
                        if (wel_pre) begin
                            kind = 2; e_start = e; busy_last = e + SECT;
                            e_base = (int'(bus.cmd_addr) / SECT) * SECT;
                        end else ne = 1'b1;
                    end
                    default: ne = 1'b1;
                endcase
            end
            exp_rv  = nv;
            exp_err = ne;
            if (nv) exp_rd = rd;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (reset_n) begin
            bit eb;
            eb = (cyc + 1 <= busy_last);
            check("cmp_ready", bus.cmd_ready, !eb || bus.cmd_op == OP_RDSR);
            check("cmp_busy", bus.busy, eb);
            check("cmp_wel", bus.wel, m_wel);
            check("cmp_rsp_valid", bus.rsp_valid, exp_rv);
            check("cmp_rsp_data", bus.rsp_data, exp_rd);
            check("cmp_err", bus.err, exp_err);
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+2; returns at posedge+2 after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output int stalls);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        stalls = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                @(posedge clk); #2;
                bus.cmd_valid = 1'b0;
                return;
            end
            stalls++;
            @(posedge clk); #2;
        end
        ntot++;
        $display("FAIL accept_timeout: op %0d never accepted", op);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
        end
        check("idle_reached", bus.busy, 1'b0);
        @(posedge clk); #2;
    endtask

    task automatic prog(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int st;
        issue(OP_WREN, '0, '0, st);
        issue(OP_PROG, a, d, st);
        wait_idle();
    endtask

    task automatic read_lit(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        int st;
        issue(OP_READ, a, '0, st);
        @(negedge clk);
        check({name, "_valid"}, bus.rsp_valid, 1'b1);
        check(name, bus.rsp_data, exp);
        @(posedge clk); #2;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, nb, nw, lastw, cnt;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #2;
        check("rst_ready", bus.cmd_ready, 1'b1);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_rsp_data", bus.rsp_data, 8'hFF);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_wel", bus.wel, 1'b0);
        check("rst_err", bus.err, 1'b0);
        @(posedge clk); #2;
        reset_n = 1'b1;
        @(posedge clk); #2;

        read_lit("read_erased_10", 8'h10, 8'hFF);

        // Program timing observed through back-to-back RDSR polling
        issue(OP_WREN, '0, '0, st);
        issue(OP_PROG, 8'h10, 8'hA5, st);
        bus.cmd_op = OP_RDSR; bus.cmd_valid = 1'b1;
        nb = 0; nw = 0; lastw = 1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                nb += int'(bus.rsp_data[0]);
                nw += int'(bus.rsp_data[1]);
                lastw = int'(bus.rsp_data[1]);
            end
        end
        @(posedge clk); #2;
        bus.cmd_valid = 1'b0;
        check("prog_busy_cycles", nb, 4);
        check("prog_wel_cycles", nw, 4);
        check("prog_wel_final", lastw, 0);
        prog(8'h10, 8'h3C);
        read_lit("read_and_10", 8'h10, 8'h24);

        // Program without write enable
        issue(OP_PROG, 8'h20, 8'h00, st);
        @(negedge clk);
        check("noWEL_err", bus.err, 1'b1);
        check("noWEL_busy", bus.busy, 1'b0);
        @(posedge clk); #2;
        read_lit("read_20", 8'h20, 8'hFF);

        // Sector erase
        prog(8'h30, 8'h00);
        prog(8'h3F, 8'h00);
        prog(8'h2F, 8'h12);
        prog(8'h40, 8'h34);
        issue(OP_WREN, '0, '0, st);
        issue(OP_SERASE, 8'h37, '0, st);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            cnt++;
        end
        check("erase_busy_cycles", cnt, 16);
        @(posedge clk); #2;
        read_lit("erase_30", 8'h30, 8'hFF);
        read_lit("erase_3F", 8'h3F, 8'hFF);
        read_lit("keep_2F", 8'h2F, 8'h12);
        read_lit("keep_40", 8'h40, 8'h34);

        // Reset in the middle of a sector erase
        for (int a = 8'h50; a <= 8'h5F; a++) prog(AW'(a), DW'(a - 8'h50));
        issue(OP_WREN, '0, '0, st);
        issue(OP_SERASE, 8'h50, '0, st);
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("rstmid_busy", bus.busy, 1'b0);
        check("rstmid_wel", bus.wel, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        @(posedge clk); #2;
        for (int a = 8'h50; a <= 8'h5F; a++)
            read_lit("rstmid_word", AW'(a), (a < 8'h55) ? 8'hFF : DW'(a - 8'h50));

        // Illegal opcode
        issue(3'd7, '0, '0, st);
        @(negedge clk);
        check("illegal_err", bus.err, 1'b1);
        @(posedge clk); #2;

        // READ stalls while a program is in flight
        issue(OP_WREN, '0, '0, st);
        issue(OP_PROG, 8'h60, 8'h0F, st);
        issue(OP_READ, 8'h60, '0, st);
        @(negedge clk);
        check("stall_read_valid", bus.rsp_valid, 1'b1);
        check("stall_read_data", bus.rsp_data, 8'h0F);
        check("stall_cycles", st, 4);
        @(posedge clk); #2;

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            int r, gap;
            logic [2:0] op;
            r = $urandom_range(0, 99);
            if      (r < 25) op = OP_READ;
            else if (r < 45) op = OP_PROG;
            else if (r < 50) op = OP_SERASE;
            else if (r < 75) op = OP_WREN;
            else if (r < 80) op = OP_WRDI;
            else if (r < 93) op = OP_RDSR;
            else if (r < 96) op = 3'd6;
            else             op = 3'd7;
            issue(op, AW'($urandom_range(0, 255)), DW'($urandom_range(0, 255)), st);
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #2;
            end
        end
        repeat (20) @(posedge clk);
        #2;

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/ospi_flash_mem.md
# ospi_flash_mem

Parametrised, cycle-timed OSPI flash memory model with a command/response interface. It supports reads, program, sector erase, a write-enable latch and status readout. Program is AND-only (bits 1→0), erase restores a whole sector to all-ones, and both hold a busy flag for a defined number of cycles. It sits behind the OSPI protocol front end as the storage back end used by the cocotb benches.

## Interface
Parameters:
- DATA_W, 8, word width in bits (≥2)
- ADDR_W, 8, word address width; depth = 2^ADDR_W
- SECTOR_W, 4, log2 words per sector (< ADDR_W)
- PROG_CYCLES, 4, program busy time in cycles (≥1)

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_op  in  3  opcode: READ=0, PROG=1, SERASE=2, WREN=3, WRDI=4, RDSR=5; 6–7 illegal
- cmd_addr  in  ADDR_W  word address
- cmd_wdata  in  DATA_W  program data
- rsp_valid  out  1  one-cycle pulse, read/status data valid
- rsp_data  out  DATA_W  read or status data
- busy  out  1  program/erase in progress (WIP)
- wel  out  1  write-enable latch
- err  out  1  one-cycle pulse, command rejected

## Operation
- State machine: IDLE, PROG, ERASE. Reset → IDLE.
- cmd_ready = (state==IDLE) || (cmd_op==RDSR). RDSR is always accepted; all other ops wait while busy.
- READ: rsp_data = mem[cmd_addr].
- RDSR: rsp_data = {0…, wel, busy}, with busy at bit0 and wel at bit1. Values are sampled in the acceptance cycle.
- WREN sets wel. WRDI clears wel. Neither produces a response.
- PROG with wel=1: enter PROG and latch addr and data. On completion, mem[addr] <= mem[addr] & data, then clear wel.
- SERASE with wel=1: enter ERASE with base = cmd_addr with low SECTOR_W bits zeroed. Word base+i is written all-ones in busy cycle i, for i = 0…2^SECTOR_W−1. wel clears on completion.
- PROG/SERASE with wel=0, or an illegal opcode: no state change, wel unchanged, err pulses.
- Array contents are not affected by reset_n. The array is all-ones at time zero.
- Reset mid-operation: return to IDLE; busy, wel, rsp_valid and err go to 0. An uncommitted program is discarded. Erased words stay erased; the remaining words of the sector keep their old data.
- Reset values: cmd_ready=1 (IDLE), rsp_valid=0, rsp_data=all-ones, busy=0, wel=0, err=0.

## Timing
- Acceptance at edge T. rsp_valid/rsp_data and err are registered and appear at T+1 for one cycle.
- rsp_data holds its last value when rsp_valid=0.
- PROG accepted at T: busy=1 for cycles T+1…T+PROG_CYCLES. The array write and wel clear occur at the edge ending the last busy cycle. The next non-RDSR command is accepted at T+PROG_CYCLES+1.
- SERASE accepted at T: busy=1 for exactly 2^SECTOR_W cycles, with one word written per cycle.
- Erase counter width is SECTOR_W+1 bits. The program counter is sized for PROG_CYCLES. The address must not wrap beyond the sector.
- wel set by WREN at T is visible at T+1. Back-to-back WREN→PROG on consecutive cycles is legal.
- RDSR accepted during the final busy cycle reports busy=1.

## Structure
- Shared package ospi_flash_pkg holds:
  - opcode localparams/enum
  - status bit indices (SR_WIP=0, SR_WEL=1)
  - state encoding
- Sub-module ospi_flash_array: single-port synchronous-write, asynchronous-read array (DATA_W × 2^ADDR_W), with all-ones initialisation.
- Top level: FSM, counters, wel, and response/err registers.

## Test plan
- Reset, then READ 0x10 → rsp_valid at T+1, rsp_data=0xFF; busy=0, wel=0.
- WREN; PROG 0x10 ← 0xA5; poll RDSR → busy=1 for exactly 4 cycles, wel=1 then 0. Then WREN; PROG 0x10 ← 0x3C; READ 0x10 → 0x24 (AND semantics).
- PROG 0x20 without WREN → err pulse at T+1; busy stays 0; READ 0x20 → 0xFF.
- Program 0x30 and 0x3F to 0x00; WREN; SERASE 0x37 → busy for 16 cycles; READ 0x30, 0x3F → 0xFF; READ 0x2F and 0x40 unchanged.
- SERASE at 0x50, assert reset_n low after 5 busy cycles → 0x50–0x54 = 0xFF, 0x55–0x5F keep old data; busy=0, wel=0.
- Illegal opcode 7 → err pulse. READ issued while busy → cmd_ready=0 until busy falls, then data returned.
